// File: rtl/sp_arbiter_pkg.sv
// sp_arbiter_pkg: index-width helper and priority-direction constants shared by the arbiter files
package sp_arbiter_pkg;
  localparam int PRIO_LSB = 1;
  localparam int PRIO_MSB = 0;
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sp_arbiter_if.sv
// sp_arbiter_if: request/grant bundle (req in; gnt, gnt_vld, gnt_idx out of the arbiter)
interface sp_arbiter_if
  import sp_arbiter_pkg::*;
#(
  parameter int NUM = 4
) ();
  localparam int IDXW = idx_w(NUM);
  logic [NUM-1:0]  req;
  logic [NUM-1:0]  gnt;
  logic            gnt_vld;
  logic [IDXW-1:0] gnt_idx;
  modport master (output req, input gnt, gnt_vld, gnt_idx);
  modport slave  (input req, output gnt, gnt_vld, gnt_idx);
endinterface

// File: rtl/sp_find_first.sv
// sp_find_first: combinational first-set-bit finder (i_req -> o_onehot, o_idx), lowest bit when LSB_HIGH else highest
module sp_find_first
  import sp_arbiter_pkg::*;
#(
  parameter int NUM      = 4,
  parameter int LSB_HIGH = PRIO_LSB,
  parameter int IDXW     = idx_w(NUM)
) (
  input  logic [NUM-1:0]  i_req,
  output logic [NUM-1:0]  o_onehot,
  output logic [IDXW-1:0] o_idx
);
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    if (LSB_HIGH != PRIO_MSB) begin
      for (int i = NUM - 1; i >= 0; i--) begin
        if (i_req[i]) begin
          o_onehot    = '0;
          o_onehot[i] = 1'b1;
          o_idx       = IDXW'(i);
        end
      end
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (i_req[i]) begin
          o_onehot    = '0;
          o_onehot[i] = 1'b1;
          o_idx       = IDXW'(i);
        end
      end
    end
  end
endmodule

// File: rtl/sp_arbiter.sv
// sp_arbiter: registered fixed-priority arbiter (clk, rst, bus.req in; bus.gnt/gnt_vld/gnt_idx out)
module sp_arbiter
  import sp_arbiter_pkg::*;
#(
  parameter int NUM      = 4,
  parameter int LSB_HIGH = PRIO_LSB
) (
  input logic        clk,
  input logic        rst,
  sp_arbiter_if.slave bus
);
  localparam int IDXW = idx_w(NUM);
  logic [NUM-1:0]  w_onehot;
  logic [IDXW-1:0] w_idx;
  logic [NUM-1:0]  r_gnt;
  logic            r_gnt_vld;
  logic [IDXW-1:0] r_gnt_idx;
  sp_find_first #(.NUM(NUM), .LSB_HIGH(LSB_HIGH), .IDXW(IDXW)) u_ff (
    .i_req    (bus.req),
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt     <= '0;
      r_gnt_vld <= 1'b0;
      r_gnt_idx <= '0;
    end else begin
      r_gnt     <= w_onehot;
      r_gnt_vld <= |bus.req;
      r_gnt_idx <= w_idx;
    end
  end
  assign bus.gnt     = r_gnt;
  assign bus.gnt_vld = r_gnt_vld;
  assign bus.gnt_idx = r_gnt_idx;
endmodule

// File: tb/tb_sp_arbiter.sv
// tb_sp_arbiter: two NUM=4 arbiters (LSB and MSB priority) on one req, checked against a scoreboard each cycle
module tb_sp_arbiter;
  typedef struct {
    logic [3:0] req;
    logic [3:0] glo;
    logic [3:0] ghi;
    logic [1:0] ilo;
    logic [1:0] ihi;
    logic       vld;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  int         errors = 0;
  int         checks = 0;
  exp_t       sb[$];
  sp_arbiter_if #(.NUM(4)) if_lo ();
  sp_arbiter_if #(.NUM(4)) if_hi ();
  assign if_lo.req = req;
  assign if_hi.req = req;
  sp_arbiter #(.NUM(4), .LSB_HIGH(1)) u_lo (.clk(clk), .rst(rst), .bus(if_lo));
  sp_arbiter #(.NUM(4), .LSB_HIGH(0)) u_hi (.clk(clk), .rst(rst), .bus(if_hi));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] lowest(input logic [3:0] r);
    return r & (~r + 4'd1);
  endfunction
  function automatic logic [3:0] highest(input logic [3:0] r);
    logic [3:0] s;
    s = r | (r >> 1) | (r >> 2) | (r >> 3);
    return s ^ (s >> 1);
  endfunction
  function automatic logic [1:0] pos(input logic [3:0] oh);
    return oh[3] ? 2'd3 : oh[2] ? 2'd2 : oh[1] ? 2'd1 : 2'd0;
  endfunction
  task automatic cycle(input logic [3:0] r, input logic rs);
    exp_t e;
    @(negedge clk);
    req = r;
    rst = rs;
    e.req = r;
    e.glo = rs ? 4'b0 : lowest(r);
    e.ghi = rs ? 4'b0 : highest(r);
    e.ilo = pos(e.glo);
    e.ihi = pos(e.ghi);
    e.vld = !rs && (r != 4'b0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("lo_gnt", if_lo.gnt, e.glo);
      chk("hi_gnt", if_hi.gnt, e.ghi);
      chk("lo_idx", if_lo.gnt_idx, e.ilo);
      chk("hi_idx", if_hi.gnt_idx, e.ihi);
      chk("lo_vld", if_lo.gnt_vld, e.vld);
      chk("hi_vld", if_hi.gnt_vld, e.vld);
      chk("lo_1hot", $onehot0(if_lo.gnt), 1);
      chk("hi_1hot", $onehot0(if_hi.gnt), 1);
      chk("lo_sub", if_lo.gnt & ~e.req, 0);
      chk("hi_sub", if_hi.gnt & ~e.req, 0);
    end
  endtask
  task automatic dir(input logic [3:0] r, input logic rs, input logic [3:0] elo, input logic [3:0] ehi);
    cycle(r, rs);
    chk("dir_lo", if_lo.gnt, elo);
    chk("dir_hi", if_hi.gnt, ehi);
  endtask
  initial begin
    dir(4'b1010, 1'b1, 4'b0000, 4'b0000);
    dir(4'b0001, 1'b0, 4'b0001, 4'b0001);
    dir(4'b1010, 1'b0, 4'b0010, 4'b1000);
    dir(4'b1111, 1'b0, 4'b0001, 4'b1000);
    dir(4'b0000, 1'b0, 4'b0000, 4'b0000);
    dir(4'b1100, 1'b0, 4'b0100, 4'b1000);
    dir(4'b0110, 1'b1, 4'b0000, 4'b0000);
    dir(4'b0110, 1'b0, 4'b0010, 4'b0100);
    dir(4'b1000, 1'b0, 4'b1000, 4'b1000);
    dir(4'b1001, 1'b0, 4'b0001, 4'b1000);
    dir(4'b0100, 1'b0, 4'b0100, 4'b0100);
    for (int i = 0; i < 24; i++) cycle(4'($urandom_range(0, 15)), 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sp_arbiter.md
SP_ARBITER -- requirements
Module: sp_arbiter

Interface
REQ-001 Parameter NUM, default 4, number of requesters; legal range 1..64.
REQ-002 Parameter LSB_HIGH, default 1, priority direction; 1 = index 0 highest priority, 0 = index NUM-1 highest priority.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port req  input  NUM  request vector; bit i set = requester i requests.
REQ-006 Port gnt  output  NUM  registered one-hot grant vector.
REQ-007 Port gnt_vld  output  1  registered; high when gnt is non-zero.
REQ-008 Port gnt_idx  output  IDXW  registered binary index of the granted bit; IDXW = max(1, clog2(NUM)).

Function
REQ-009 The arbiter SHALL be fixed (strict) priority, with no fairness, rotation or history.
REQ-010 With LSB_HIGH=1, the next grant SHALL be the lowest-index set bit of req.
REQ-011 With LSB_HIGH=0, the next grant SHALL be the highest-index set bit of req.
REQ-012 Latency SHALL be one cycle: req sampled at edge N is reflected on gnt/gnt_vld/gnt_idx after edge N.
REQ-013 gnt SHALL have at most one bit set and SHALL always be a subset of the req sampled at the previous edge.
REQ-014 req = all zeros SHALL give gnt = 0, gnt_vld = 0 and gnt_idx = 0.
REQ-015 req = all ones SHALL grant bit 0 (LSB_HIGH=1) or bit NUM-1 (LSB_HIGH=0).
REQ-016 gnt_idx SHALL equal the bit position of the set gnt bit whenever gnt_vld = 1.
REQ-017 With NUM=1, gnt SHALL equal the req sampled at the previous edge, and gnt_idx SHALL be constant 0.
REQ-018 No combinational path SHALL exist from req to any output.
REQ-019 Grants SHALL NOT be held or locked: a higher-priority request arriving SHALL preempt the current grant at the next edge.

Reset
REQ-020 While rst is high at a rising edge, the registers SHALL load gnt = 0, gnt_vld = 0 and gnt_idx = 0, regardless of req.
REQ-021 Reset asserted mid-operation SHALL clear the outputs at the next edge.
REQ-022 After rst deasserts, the first edge SHALL produce a grant from the req sampled at that edge.

Structure
REQ-023 Shared package sp_arbiter_pkg SHALL hold the IDXW width function (max(1, clog2(NUM))) and the priority-direction constants PRIO_LSB = 1 and PRIO_MSB = 0.
REQ-024 One sub-module sp_find_first SHALL be used.
- Parameters NUM and LSB_HIGH.
- Combinational input req; outputs one-hot and binary index.
- Direction selected by LSB_HIGH: find lowest set bit when 1, highest set bit when 0.
REQ-025 sp_arbiter SHALL register the sp_find_first outputs, plus the OR-reduction of req as gnt_vld.

Verification
REQ-026 Two instances (NUM=4, LSB_HIGH=1 and NUM=4, LSB_HIGH=0) SHALL share one req stimulus and be checked against a reference model every cycle.
REQ-027 Scenario: req=0001 -> LSB_HIGH=1 instance gnt=0001, idx=0; LSB_HIGH=0 instance gnt=0001, idx=0; both vld=1.
REQ-028 Scenario: req=1010 -> LSB_HIGH=1 instance gnt=0010, idx=1; LSB_HIGH=0 instance gnt=1000, idx=3.
REQ-029 Scenario: req=1111 -> LSB_HIGH=1 instance gnt=0001; LSB_HIGH=0 instance gnt=1000. Then req=0000 -> both gnt=0000, vld=0.
REQ-030 Scenario: rst=1 while req=0110 -> gnt=0000, vld=0 at the next edge. Then rst=0 -> LSB_HIGH=1 instance gnt=0010; LSB_HIGH=0 instance gnt=0100.
REQ-031 Scenario: 20+ random req values, one per 10 ns clock. Each cycle the bench SHALL check one-hot-or-zero, subset of the previous req, priority per REQ-010/REQ-011, and the one-cycle latency.
